sc_dmem_initiator: RTL

- Bus-initiator engine on the single-cycle computer's data-memory/I-O interface. It drives the same addr/datain/we signals the CPU drives and samples dataout.
- Performs block copy (source to destination) or block fill (constant to destination) of up to 2^LEN_W-1 words, with a start/busy/done handshake.
- Addresses with addr[7]=1 reach the I/O space. Copying from I/O addresses captures input ports into RAM; copying or filling to I/O addresses drives output ports.
- Sits beside the CPU; a top-level mux selects which initiator owns the bus.

---
 rtl/sc_dmem_initiator_if.sv | 29 ++
 rtl/sc_dmem_initiator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sc_dmem_initiator_if.sv
// Control and data-memory bus bundle shared by the block-transfer initiator and
// whatever drives its requests and answers its bus cycles.
interface sc_dmem_initiator_if #(
    parameter int LEN_W = 6
);
    logic             start;
    logic             op;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic [31:0]      fill_value;
    logic [31:0]      dataout;
    logic [31:0]      addr;
    logic [31:0]      datain;
    logic             we;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_done;

    modport master (
        input  start, op, src_addr, dst_addr, len, fill_value, dataout,
        output addr, datain, we, busy, done, words_done
    );

    modport slave (
        output start, op, src_addr, dst_addr, len, fill_value, dataout,
        input  addr, datain, we, busy, done, words_done
    );
endinterface

// File: rtl/sc_dmem_initiator.sv
// Block copy / block fill engine that masters the single-cycle computer's
// data-memory and I/O bus; every bus output comes straight from a flop.
module sc_dmem_initiator #(
    parameter int RD_LAT = 1,
    parameter int LEN_W  = 6
) (
    input logic                 clock,
    input logic                 reset,
    sc_dmem_initiator_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [2:0]  WAIT_INIT  = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_t           state, state_nxt;
    logic             op_q, op_nxt;
    logic [31:0]      src_ptr, src_nxt;
    logic [31:0]      dst_ptr, dst_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [31:0]      fill_q, fill_nxt;
    logic [31:0]      data_q, data_nxt;
    logic [2:0]       wait_cnt, wait_nxt;
    logic [LEN_W-1:0] words_done, words_nxt, words_inc;

    logic [31:0] addr_q, addr_nxt;
    logic [31:0] datain_q, datain_nxt;
    logic        we_q, we_nxt;
    logic        busy_q, busy_nxt;
    logic        done_q, done_nxt;

    assign words_inc = words_done + LEN_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= 1'b0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            data_q     <= '0;
            wait_cnt   <= '0;
            words_done <= '0;
            addr_q     <= '0;
            datain_q   <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            op_q       <= op_nxt;
            src_ptr    <= src_nxt;
            dst_ptr    <= dst_nxt;
            len_q      <= len_nxt;
            fill_q     <= fill_nxt;
            data_q     <= data_nxt;
            wait_cnt   <= wait_nxt;
            words_done <= words_nxt;
            addr_q     <= addr_nxt;
            datain_q   <= datain_nxt;
            we_q       <= we_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
        end
    end

    // wait_cnt holds the number of WAIT cycles still to come after the current one
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        src_nxt   = src_ptr;
        dst_nxt   = dst_ptr;
        len_nxt   = len_q;
        fill_nxt  = fill_q;
        data_nxt  = data_q;
        wait_nxt  = wait_cnt;
        words_nxt = words_done;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    op_nxt    = bus.op;
                    src_nxt   = bus.src_addr & ALIGN_MASK;
                    dst_nxt   = bus.dst_addr & ALIGN_MASK;
                    len_nxt   = bus.len;
                    fill_nxt  = bus.fill_value;
                    words_nxt = '0;
                    if (bus.len == '0)
                        state_nxt = S_DONE;
                    else if (bus.op)
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (RD_LAT == 1) begin
                    data_nxt  = bus.dataout;
                    state_nxt = S_WR;
                end else begin
                    wait_nxt  = WAIT_INIT;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    data_nxt  = bus.dataout;
                    state_nxt = S_WR;
                end else begin
                    wait_nxt = wait_cnt - 3'd1;
                end
            end
            S_WR: begin
                words_nxt = words_inc;
                src_nxt   = src_ptr + 32'd4;
                dst_nxt   = dst_ptr + 32'd4;
                if (words_inc == len_q)
                    state_nxt = S_DONE;
                else if (op_q)
                    state_nxt = S_WR;
                else
                    state_nxt = S_RD;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the state being entered so they can be registered
    always_comb begin
        addr_nxt   = '0;
        datain_nxt = '0;
        we_nxt     = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        case (state_nxt)
            S_RD, S_WAIT: begin
                addr_nxt = src_nxt;
                busy_nxt = 1'b1;
            end
            S_WR: begin
                addr_nxt   = dst_nxt;
                datain_nxt = op_nxt ? fill_nxt : data_nxt;
                we_nxt     = 1'b1;
                busy_nxt   = 1'b1;
            end
            S_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    assign bus.addr       = addr_q;
    assign bus.datain     = datain_q;
    assign bus.we         = we_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.words_done = words_done;

endmodule
